// File: rtl/leftunpad_if.sv
// leftunpad_if: character stream bus for leftunpad; master drives the padded stream, slave returns the unpadded one.
// The overflow signal exists only when LEFTUNPAD_OVERFLOW_EN is defined.
interface leftunpad_if #(parameter int STR_LEN_MAX = 8, parameter int CHAR_W = 8);
    localparam int LW = $clog2(STR_LEN_MAX + 1);
    localparam int PW = $clog2(2 * STR_LEN_MAX + 1);
    logic              start;
    logic [CHAR_W-1:0] cpad;
    logic              in_en;
    logic [CHAR_W-1:0] cin;
    logic              in_last;
    logic [CHAR_W-1:0] cout;
    logic              out_en;
    logic [LW-1:0]     out_len;
    logic [PW-1:0]     padcnt;
    logic              done;
`ifdef LEFTUNPAD_OVERFLOW_EN
    logic              overflow;
`endif
    modport master (
        output start, cpad, in_en, cin, in_last,
        input  cout, out_en, out_len, padcnt, done
`ifdef LEFTUNPAD_OVERFLOW_EN
        , input overflow
`endif
    );
    modport slave (
        input  start, cpad, in_en, cin, in_last,
        output cout, out_en, out_len, padcnt, done
`ifdef LEFTUNPAD_OVERFLOW_EN
        , output overflow
`endif
    );
endinterface

// File: rtl/leftunpad.sv
// leftunpad: strips leading pad characters from a stream, buffers the remainder and replays it.
// Define LEFTUNPAD_OVERFLOW_EN to add a sticky overflow flag for beats dropped on a full buffer.
module leftunpad #(
    parameter int STR_LEN_MAX = 8,
    parameter int CHAR_W = 8
) (
    input logic clk,
    input logic rst_n,
    leftunpad_if.slave bus
);
    localparam int LW = $clog2(STR_LEN_MAX + 1);
    localparam int AW = STR_LEN_MAX > 1 ? $clog2(STR_LEN_MAX) : 1;
    localparam logic [LW-1:0] MAX_LEN = LW'(STR_LEN_MAX);
    typedef enum logic [2:0] {ST_IDLE, ST_STRIP, ST_BUF, ST_EMIT, ST_DONE} state_t;
    state_t state;
    logic [CHAR_W-1:0] pad;
    logic [CHAR_W-1:0] mem [STR_LEN_MAX];
    logic [LW-1:0] idx;
    logic full, wr;
    assign full = bus.out_len == MAX_LEN;
    assign wr = bus.in_en && !full && (state == ST_BUF || (state == ST_STRIP && bus.cin != pad));
    always_ff @(posedge clk) begin
        if (wr) mem[bus.out_len[AW-1:0]] <= bus.cin;
    end
    // Emission is registered: the in_last edge already presents the first character.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            pad         <= '0;
            idx         <= '0;
            bus.cout    <= '0;
            bus.out_en  <= 1'b0;
            bus.done    <= 1'b0;
            bus.out_len <= '0;
            bus.padcnt  <= '0;
`ifdef LEFTUNPAD_OVERFLOW_EN
            bus.overflow <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE, ST_DONE: if (bus.start) begin
                    pad         <= bus.cpad;
                    idx         <= '0;
                    bus.out_len <= '0;
                    bus.padcnt  <= '0;
                    bus.done    <= 1'b0;
`ifdef LEFTUNPAD_OVERFLOW_EN
                    bus.overflow <= 1'b0;
`endif
                    state       <= ST_STRIP;
                end
                ST_STRIP: if (bus.in_en) begin
                    if (bus.cin == pad) begin
                        if (bus.padcnt != '1) bus.padcnt <= bus.padcnt + 1'b1;
                        if (bus.in_last) begin
                            bus.done <= 1'b1;
                            state    <= ST_DONE;
                        end
                    end else begin
                        bus.out_len <= LW'(1);
                        if (bus.in_last) begin
                            bus.out_en <= 1'b1;
                            bus.cout   <= bus.cin;
                            idx        <= LW'(1);
                            state      <= ST_EMIT;
                        end else begin
                            state <= ST_BUF;
                        end
                    end
                end
                ST_BUF: if (bus.in_en) begin
                    if (!full) bus.out_len <= bus.out_len + 1'b1;
`ifdef LEFTUNPAD_OVERFLOW_EN
                    else bus.overflow <= 1'b1;
`endif
                    if (bus.in_last) begin
                        bus.out_en <= 1'b1;
                        bus.cout   <= mem[0];
                        idx        <= LW'(1);
                        state      <= ST_EMIT;
                    end
                end
                ST_EMIT: if (idx == bus.out_len) begin
                    bus.out_en <= 1'b0;
                    bus.cout   <= '0;
                    bus.done   <= 1'b1;
                    state      <= ST_DONE;
                end else begin
                    bus.cout <= mem[idx[AW-1:0]];
                    idx      <= idx + 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_leftunpad.sv
// tb_leftunpad: directed streams with a scoreboard queue of expected output characters.
module tb_leftunpad;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q [$];

    leftunpad_if #(.STR_LEN_MAX(8), .CHAR_W(8)) bus ();
    leftunpad #(.STR_LEN_MAX(8), .CHAR_W(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops one expected character per out_en cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.out_en) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_out: got cout %0h with empty scoreboard", bus.cout);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    if (bus.cout !== e) begin
                        errors++;
                        $display("FAIL cout: got %0h expected %0h", bus.cout, e);
                    end
                end
            end else begin
                chk("cout_idle", 32'(bus.cout), 0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input string s);
        for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
    endtask

    task automatic do_start(input logic [7:0] c);
        bus.start = 1'b1;
        bus.cpad = c;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic send(input string s, input int gap, input bit last);
        for (int i = 0; i < s.len(); i++) begin
            bus.in_en = 1'b1;
            bus.cin = s[i];
            bus.in_last = last && (i == s.len() - 1);
            tick();
            bus.in_en = 1'b0;
            bus.in_last = 1'b0;
            repeat (gap) tick();
        end
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!bus.done && n < 100) begin
            tick();
            n++;
        end
        chk({name, "_done"}, 32'(bus.done), 1);
        chk({name, "_drained"}, exp_q.size(), 0);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.cpad = 8'h0;
        bus.in_en = 1'b0;
        bus.cin = 8'h0;
        bus.in_last = 1'b0;
        repeat (2) tick();
        chk("rst_out_en", 32'(bus.out_en), 0);
        chk("rst_cout", 32'(bus.cout), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_out_len", 32'(bus.out_len), 0);
        chk("rst_padcnt", 32'(bus.padcnt), 0);
`ifdef LEFTUNPAD_OVERFLOW_EN
        chk("rst_overflow", 32'(bus.overflow), 0);
`endif
        rst_n = 1'b1;
        tick();

        do_start("!");
        push_exp("foo");
        send("!!foo", 0, 1);
        chk("t1_latency", 32'(bus.out_en), 1);
        wait_done("t1");
        chk("t1_padcnt", 32'(bus.padcnt), 2);
        chk("t1_out_len", 32'(bus.out_len), 3);
`ifdef LEFTUNPAD_OVERFLOW_EN
        chk("t1_overflow", 32'(bus.overflow), 0);
`endif

        do_start("!");
        send("!!!", 0, 1);
        wait_done("t2");
        chk("t2_padcnt", 32'(bus.padcnt), 3);
        chk("t2_out_len", 32'(bus.out_len), 0);

        do_start("!");
        push_exp("f!o");
        send("!f!o", 2, 1);
        wait_done("t3");
        chk("t3_padcnt", 32'(bus.padcnt), 1);
        chk("t3_out_len", 32'(bus.out_len), 3);

        do_start("!");
        push_exp("abcdefgh");
        send("abcdefghij", 0, 1);
        wait_done("t4");
        chk("t4_out_len", 32'(bus.out_len), 8);
        chk("t4_padcnt", 32'(bus.padcnt), 0);
`ifdef LEFTUNPAD_OVERFLOW_EN
        chk("t4_overflow", 32'(bus.overflow), 1);
`endif

        do_start("!");
        push_exp("x");
        send("xyz", 0, 1);
        tick();
        chk("t5_emit2", 32'(bus.out_en), 1);
        rst_n = 1'b0;
        bus.start = 1'b1;
        bus.cpad = "q";
        #1;
        chk("t5_rst_out_en", 32'(bus.out_en), 0);
        chk("t5_rst_cout", 32'(bus.cout), 0);
        chk("t5_rst_done", 32'(bus.done), 0);
        chk("t5_rst_out_len", 32'(bus.out_len), 0);
        repeat (2) tick();
        bus.start = 1'b0;
        rst_n = 1'b1;
        tick();
        send("q", 0, 1);
        repeat (3) tick();
        chk("t5_idle_done", 32'(bus.done), 0);
        chk("t5_idle_out_len", 32'(bus.out_len), 0);
        chk("t5_drained", exp_q.size(), 0);

        do_start("!");
        push_exp("ab!c");
        send("!!ab", 0, 0);
        do_start("z");
        send("!c", 0, 1);
        wait_done("t6");
        chk("t6_padcnt", 32'(bus.padcnt), 2);
        chk("t6_out_len", 32'(bus.out_len), 4);

        do_start(" ");
        push_exp("x");
        send("  x", 0, 1);
        wait_done("t7");
        chk("t7_padcnt", 32'(bus.padcnt), 2);
        chk("t7_out_len", 32'(bus.out_len), 1);

        repeat (2) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
